// File: rtl/mult_add_seq.sv
// Sequential multiply-accumulate: sums N_PAIRS products a*b per job
// through one shared multiplier, then holds the result until consumed.
module mult_add_seq #(
  parameter int W       = 4,
  parameter int N_PAIRS = 4,
  parameter int XW      = 2*W + $clog2(N_PAIRS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] x,
  output logic          busy
);

  localparam int CW = $clog2(N_PAIRS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_PAIRS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        r_state;
  logic [XW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_busy;

  logic [2*W-1:0] w_prod;
  logic [XW-1:0]  w_sum;

  assign w_prod = a * b;
  assign w_sum  = r_acc + {{(XW-2*W){1'b0}}, w_prod};

  // The accumulator doubles as x, so the last result persists in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (clr) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= ACC;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ACC: begin
          if (in_valid) begin
            r_acc <= w_sum;
            if (r_cnt == LAST) begin
              r_cnt       <= '0;
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign x         = r_acc;

endmodule

// File: tb/tb_mult_add_seq.sv
// Scoreboard bench for mult_add_seq: directed jobs, expected sums queued,
// monitor pops on each out_valid/out_ready handshake.
module tb_mult_add_seq;

  localparam int W  = 4;
  localparam int NP = 4;
  localparam int XW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] x;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  mult_add_seq #(.W(W), .N_PAIRS(NP)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compare x against the scoreboard on every accepted result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got x=%0d expected no result", x);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(x) != e) begin
          errors++;
          $display("FAIL sb_result: got x=%0d expected %0d", x, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int va, input int vb);
    in_valid = 1'b1;
    a = W'(va);
    b = W'(vb);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; clr = 0; in_valid = 0;
    a = 0; b = 0; out_ready = 0;
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", x, 0);
    rst = 1'b0;
    tick();

    // Basic job: 15+14+225+1
    out_ready = 1'b1;
    do_start();
    chk("basic_busy", busy, 1);
    exp_q.push_back(255);
    send(3, 5); send(2, 7); send(15, 15); send(1, 1);
    chk("basic_ovalid", out_valid, 1);
    chk("basic_x", x, 255);
    tick();
    chk("basic_ovalid_1cyc", out_valid, 0);
    chk("basic_busy_fall", busy, 0);

    // Max values with back-pressure
    out_ready = 1'b0;
    do_start();
    for (int i = 0; i < NP; i++) send(15, 15);
    for (int i = 0; i < 5; i++) begin
      chk("max_hold_valid", out_valid, 1);
      chk("max_hold_x", x, 900);
      tick();
    end
    exp_q.push_back(900);
    out_ready = 1'b1;
    tick();
    chk("max_idle_busy", busy, 0);
    chk("max_retain_x", x, 900);

    // Stalls, with a stray start mid-job
    do_start();
    exp_q.push_back(100);
    send(1, 2); send(3, 4);
    a = 4'd9; b = 4'd9;
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      tick();
      chk("stall_x", x, 14);
      chk("stall_in_ready", in_ready, 1);
    end
    start = 1'b0;
    send(5, 6); send(7, 8);
    chk("stall_ovalid", out_valid, 1);
    chk("stall_x_final", x, 100);
    tick();
    chk("stall_busy_fall", busy, 0);

    // Abort with a concurrent transfer
    do_start();
    send(2, 3); send(4, 5);
    chk("abort_pre_x", x, 26);
    clr = 1'b1; in_valid = 1'b1; a = 4'd9; b = 4'd9;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_x", x, 0);
    chk("abort_in_ready", in_ready, 0);
    do_start();
    exp_q.push_back(4);
    for (int i = 0; i < NP; i++) send(1, 1);
    chk("abort_next_x", x, 4);
    tick();

    // Async reset in HOLD
    out_ready = 1'b0;
    do_start();
    send(3, 5); send(2, 7); send(15, 15); send(1, 1);
    chk("arst_pre_valid", out_valid, 1);
    chk("arst_pre_x", x, 255);
    #2 rst = 1'b1;
    #1;
    chk("arst_ovalid", out_valid, 0);
    chk("arst_x", x, 0);
    chk("arst_busy", busy, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send(7, 7);
    chk("arst_no_start_busy", busy, 0);
    chk("arst_no_start_x", x, 0);
    chk("arst_no_start_rdy", in_ready, 0);

    // out_ready and start collide in HOLD
    do_start();
    exp_q.push_back(4);
    for (int i = 0; i < NP; i++) send(1, 1);
    chk("coll_ovalid", out_valid, 1);
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    chk("coll_busy", busy, 0);
    chk("coll_ovalid_low", out_valid, 0);
    tick();
    chk("coll_no_restart", busy, 0);
    do_start();
    chk("coll_new_busy", busy, 1);
    exp_q.push_back(16);
    for (int i = 0; i < NP; i++) send(2, 2);
    chk("coll_new_x", x, 16);
    out_ready = 1'b1;
    tick();
    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
